// File: rtl/setup_menu_param.sv
// setup_menu_param
// Setup menu for the lock. Walks the operator through bip enable, bip time,
// auto-lock time, master password and NUM_USERS user passwords. Edits go to
// a shadow copy of the configuration, which is committed to the lock core
// only when the menu reaches SAVE.
//
// Optional feature: define SETUP_TIMEOUT_EN to abort the menu (no commit)
// after TIMEOUT_CYCLES cycles without a confirmed entry or field change.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   setup_on        enter-menu request, only looked at in IDLE
//   digitos_value   20 packed digits, [3:0] is the most recent, F = empty
//   digitos_valid   one-cycle strobe, entry confirmed
//   display_en      display owned by this block
//   bcd_pac         BCD5..BCD0 ([23:20] .. [3:0]), B = blank
//   bip_status      committed bip enable
//   bip_time        committed bip time (s)
//   tranca_time     committed auto-lock time (s)
//   senha_master    committed master password, F-padded
//   senha_users     committed user passwords, slot k at [80k+79:80k]
//   data_setup_ok   one-cycle pulse in the SAVE cycle
//
// state       | meaning
// ------------+-------------------------------------------------
// IDLE        | menu closed, display released
// BIP_EN      | field 1, bip enable (0/1)
// BIP_TIME    | field 2, bip time, clamped to [T_MIN,T_MAX]
// LOCK_TIME   | field 3, auto-lock time, clamped to [T_MIN,T_MAX]
// PW_MASTER   | field 4, master password
// PW_USER     | field 5+idx, user password slot idx
// SAVE        | one cycle, committed config just loaded, ok pulse

module setup_menu_param #(
    parameter int NUM_USERS      = 4,
    parameter int PW_MIN         = 4,
    parameter int PW_MAX         = 12,
    parameter int T_MIN          = 5,
    parameter int T_MAX          = 60,
    parameter int T_DEFAULT      = 5,
    parameter int TIMEOUT_CYCLES = 30_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     setup_on,
    input  logic [79:0]              digitos_value,
    input  logic                     digitos_valid,
    output logic                     display_en,
    output logic [23:0]              bcd_pac,
    output logic                     bip_status,
    output logic [6:0]               bip_time,
    output logic [6:0]               tranca_time,
    output logic [79:0]              senha_master,
    output logic [NUM_USERS*80-1:0]  senha_users,
    output logic                     data_setup_ok
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_BIP_EN    = 3'd1;
    localparam logic [2:0] S_BIP_TIME  = 3'd2;
    localparam logic [2:0] S_LOCK_TIME = 3'd3;
    localparam logic [2:0] S_PW_MASTER = 3'd4;
    localparam logic [2:0] S_PW_USER   = 3'd5;
    localparam logic [2:0] S_SAVE      = 3'd6;

    localparam logic [3:0]  DIG_B = 4'hB;
    localparam logic [3:0]  DIG_E = 4'hE;
    localparam logic [3:0]  DIG_F = 4'hF;
    localparam logic [79:0] ALL_F = {20{4'hF}};
    localparam logic [79:0] ALL_B = {20{4'hB}};
    localparam logic [79:0] ALL_E = {20{4'hE}};

    localparam logic [79:0] MASTER_DEFAULT = 80'hFFFF_FFFF_FFFF_FFFF_1234;
    localparam logic [NUM_USERS*80-1:0] USERS_DEFAULT = '1;

    localparam logic [6:0] T_MIN7     = 7'(T_MIN);
    localparam logic [6:0] T_MAX7     = 7'(T_MAX);
    localparam logic [6:0] T_DEFAULT7 = 7'(T_DEFAULT);
    localparam logic [2:0] LAST_IDX   = 3'(NUM_USERS - 1);
    localparam int         PW_MIN_LSB = (PW_MIN - 1) * 4;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    logic [2:0]              state, state_nxt;
    logic [2:0]              idx, idx_nxt;
    logic                    err, err_nxt;
    logic [3:0]              pend_hi, pend_hi_nxt;
    logic [3:0]              pend_lo, pend_lo_nxt;

    logic                    sh_bip, sh_bip_nxt;
    logic [6:0]              sh_bt, sh_bt_nxt;
    logic [6:0]              sh_lt, sh_lt_nxt;
    logic [79:0]             sh_master, sh_master_nxt;
    logic [NUM_USERS*80-1:0] sh_users, sh_users_nxt;

    logic                    cm_bip;
    logic [6:0]              cm_bt;
    logic [6:0]              cm_lt;
    logic [79:0]             cm_master;
    logic [NUM_USERS*80-1:0] cm_users;

    logic [3:0]  d0, d1;
    logic        is_all_f, is_all_b, is_all_e;
    logic        t_bad;
    logic [6:0]  t_raw, t_clamped;
    logic [79:0] pw_cand;
    logic        pw_short;
    logic        coll_user;
    logic        edit;
    logic        advance, reload;
    logic [7:0]  bcd_tmp;

`ifdef SETUP_TIMEOUT_EN
    localparam int            TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    assign d0       = digitos_value[3:0];
    assign d1       = digitos_value[7:4];
    assign is_all_f = (digitos_value == ALL_F);
    assign is_all_b = (digitos_value == ALL_B);
    assign is_all_e = (digitos_value == ALL_E);

    // Tens digit may be empty (single-digit entry); units must be BCD.
    assign t_bad = (d0 > 4'd9) || ((d1 > 4'd9) && (d1 != DIG_F));
    assign t_raw = (d1 == DIG_F) ? 7'(d0) : (7'(d1) * 7'd10 + 7'(d0));

    always_comb begin
        t_clamped = t_raw;
        if (t_raw < T_MIN7) t_clamped = T_MIN7;
        else if (t_raw > T_MAX7) t_clamped = T_MAX7;
    end

    always_comb begin
        pw_cand = ALL_F;
        for (int i = 0; i < 20; i++) begin
            if (i < PW_MAX) pw_cand[i*4 +: 4] = digitos_value[i*4 +: 4];
        end
    end

    assign pw_short = (digitos_value[PW_MIN_LSB +: 4] == DIG_F);

    // Empty user slots never collide with the master.
    always_comb begin
        coll_user = 1'b0;
        for (int k = 0; k < NUM_USERS; k++) begin
            if ((sh_users[k*80 +: 80] != ALL_F) && (sh_users[k*80 +: 80] == pw_cand))
                coll_user = 1'b1;
        end
    end

    assign edit = (state == S_BIP_EN) || (state == S_BIP_TIME) || (state == S_LOCK_TIME) ||
                  (state == S_PW_MASTER) || (state == S_PW_USER);

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        err_nxt       = err;
        pend_hi_nxt   = pend_hi;
        pend_lo_nxt   = pend_lo;
        sh_bip_nxt    = sh_bip;
        sh_bt_nxt     = sh_bt;
        sh_lt_nxt     = sh_lt;
        sh_master_nxt = sh_master;
        sh_users_nxt  = sh_users;
        advance       = 1'b0;
        reload        = 1'b0;
        bcd_tmp       = 8'hBB;

        case (state)
            S_IDLE: begin
                if (setup_on) begin
                    state_nxt     = S_BIP_EN;
                    idx_nxt       = 3'd0;
                    sh_bip_nxt    = cm_bip;
                    sh_bt_nxt     = cm_bt;
                    sh_lt_nxt     = cm_lt;
                    sh_master_nxt = cm_master;
                    sh_users_nxt  = cm_users;
                end
            end
            S_SAVE: state_nxt = S_IDLE;
            default: begin
                if (!edit) begin
                    state_nxt = S_IDLE;
                end else if (digitos_valid) begin
                    if (is_all_f) begin
                        advance = 1'b1;
                    end else if (is_all_b) begin
                        state_nxt = S_SAVE;
                    end else if (is_all_e) begin
                        reload = 1'b1;
                    end else begin
                        case (state)
                            S_BIP_EN: begin
                                if (d0 <= 4'd1) begin
                                    sh_bip_nxt = d0[0];
                                    advance    = 1'b1;
                                end else begin
                                    err_nxt = 1'b1;
                                end
                            end
                            S_BIP_TIME, S_LOCK_TIME: begin
                                if (t_bad) begin
                                    err_nxt = 1'b1;
                                end else begin
                                    if (state == S_BIP_TIME) sh_bt_nxt = t_clamped;
                                    else                     sh_lt_nxt = t_clamped;
                                    advance = 1'b1;
                                end
                            end
                            S_PW_MASTER: begin
                                if (pw_short || coll_user) begin
                                    err_nxt = 1'b1;
                                end else begin
                                    sh_master_nxt = pw_cand;
                                    advance       = 1'b1;
                                end
                            end
                            default: begin
                                if (pw_short || (pw_cand == sh_master)) begin
                                    err_nxt = 1'b1;
                                end else begin
                                    sh_users_nxt[idx*80 +: 80] = pw_cand;
                                    advance                    = 1'b1;
                                end
                            end
                        endcase
                    end
                end else begin
                    // Live preview of the entry being typed; empty shows the shadow.
                    if (state == S_BIP_EN) begin
                        pend_lo_nxt = (d0 <= 4'd1) ? d0 : {3'b000, sh_bip};
                    end else if ((state == S_BIP_TIME) || (state == S_LOCK_TIME)) begin
                        if (d0 == DIG_F) begin
                            bcd_tmp     = to_bcd((state == S_BIP_TIME) ? sh_bt : sh_lt);
                            pend_hi_nxt = bcd_tmp[7:4];
                            pend_lo_nxt = bcd_tmp[3:0];
                        end else begin
                            pend_hi_nxt = (d1 == DIG_F) ? 4'd0 : d1;
                            pend_lo_nxt = d0;
                        end
                    end
                end

                if (advance) begin
                    case (state)
                        S_BIP_EN:    state_nxt = S_BIP_TIME;
                        S_BIP_TIME:  state_nxt = S_LOCK_TIME;
                        S_LOCK_TIME: state_nxt = S_PW_MASTER;
                        S_PW_MASTER: begin
                            state_nxt = S_PW_USER;
                            idx_nxt   = 3'd0;
                        end
                        default: begin
                            if (idx == LAST_IDX) state_nxt = S_SAVE;
                            else                 idx_nxt   = idx + 3'd1;
                        end
                    endcase
                end
            end
        endcase

`ifdef SETUP_TIMEOUT_EN
        if (edit && !digitos_valid && (to_cnt == TO_LAST)) begin
            state_nxt     = S_IDLE;
            idx_nxt       = 3'd0;
            sh_bip_nxt    = cm_bip;
            sh_bt_nxt     = cm_bt;
            sh_lt_nxt     = cm_lt;
            sh_master_nxt = cm_master;
            sh_users_nxt  = cm_users;
        end
`endif

        // Entering a field (or abandoning the typed entry) shows the shadow value.
        if ((state_nxt != state) || (idx_nxt != idx) || reload) begin
            if ((state_nxt != state) || (idx_nxt != idx)) err_nxt = 1'b0;
            case (state_nxt)
                S_BIP_EN: begin
                    pend_hi_nxt = DIG_B;
                    pend_lo_nxt = {3'b000, sh_bip_nxt};
                end
                S_BIP_TIME: begin
                    bcd_tmp     = to_bcd(sh_bt_nxt);
                    pend_hi_nxt = bcd_tmp[7:4];
                    pend_lo_nxt = bcd_tmp[3:0];
                end
                S_LOCK_TIME: begin
                    bcd_tmp     = to_bcd(sh_lt_nxt);
                    pend_hi_nxt = bcd_tmp[7:4];
                    pend_lo_nxt = bcd_tmp[3:0];
                end
                default: begin
                    pend_hi_nxt = DIG_B;
                    pend_lo_nxt = DIG_B;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            err       <= 1'b0;
            pend_hi   <= DIG_B;
            pend_lo   <= DIG_B;
            sh_bip    <= 1'b1;
            sh_bt     <= T_DEFAULT7;
            sh_lt     <= T_DEFAULT7;
            sh_master <= MASTER_DEFAULT;
            sh_users  <= USERS_DEFAULT;
            cm_bip    <= 1'b1;
            cm_bt     <= T_DEFAULT7;
            cm_lt     <= T_DEFAULT7;
            cm_master <= MASTER_DEFAULT;
            cm_users  <= USERS_DEFAULT;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            err       <= err_nxt;
            pend_hi   <= pend_hi_nxt;
            pend_lo   <= pend_lo_nxt;
            sh_bip    <= sh_bip_nxt;
            sh_bt     <= sh_bt_nxt;
            sh_lt     <= sh_lt_nxt;
            sh_master <= sh_master_nxt;
            sh_users  <= sh_users_nxt;
            // Commit on the way into SAVE so the SAVE cycle already shows it.
            if ((state_nxt == S_SAVE) && (state != S_SAVE)) begin
                cm_bip    <= sh_bip_nxt;
                cm_bt     <= sh_bt_nxt;
                cm_lt     <= sh_lt_nxt;
                cm_master <= sh_master_nxt;
                cm_users  <= sh_users_nxt;
            end
        end
    end

`ifdef SETUP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (digitos_valid || (state_nxt != state)) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`endif

    logic [3:0] err_dig;
    assign err_dig = err ? DIG_E : DIG_B;

    always_comb begin
        bcd_pac = {6{DIG_B}};
        case (state)
            S_BIP_EN:    bcd_pac = {4'd1, err_dig, DIG_B, DIG_B, DIG_B, pend_lo};
            S_BIP_TIME:  bcd_pac = {4'd2, err_dig, DIG_B, DIG_B, pend_hi, pend_lo};
            S_LOCK_TIME: bcd_pac = {4'd3, err_dig, DIG_B, DIG_B, pend_hi, pend_lo};
            S_PW_MASTER: bcd_pac = {4'd4, err_dig, DIG_B, DIG_B, DIG_B, DIG_B};
            S_PW_USER:   bcd_pac = {4'd5 + 4'(idx), err_dig, DIG_B, DIG_B, DIG_B, DIG_B};
            default:     bcd_pac = {6{DIG_B}};
        endcase
    end

    assign display_en    = (state != S_IDLE);
    assign data_setup_ok = (state == S_SAVE);
    assign bip_status    = cm_bip;
    assign bip_time      = cm_bt;
    assign tranca_time   = cm_lt;
    assign senha_master  = cm_master;
    assign senha_users   = cm_users;

endmodule

// File: doc/setup_menu_param.md
# setup_menu_param

Parametrised successor of the lock's setup menu FSM: walks the operator through bip enable, bip time, auto-lock time, master password and `NUM_USERS` user passwords. It edits a shadow copy of the configuration and commits it to the lock core only on save. It sits between the keypad digit packer (`senhaPac_t` producer) and the lock core / 7-segment driver. It adds bounded time clamping, master/user password collision rejection, an error indication and an optional inactivity abort.

## Interface
- `NUM_USERS`, 4 — user password slots, 1..5 (field numbers must fit one BCD digit).
- `PW_MIN`, 4 — minimum password digits accepted.
- `PW_MAX`, 12 — maximum stored password digits (≤20).
- `T_MIN`, 5 — lower clamp for both times (s).
- `T_MAX`, 60 — upper clamp for both times (s); ≤99.
- `T_DEFAULT`, 5 — reset value of both times; must lie within [T_MIN,T_MAX].
- `TIMEOUT_CYCLES`, 30_000_000 — inactivity limit, used only with `SETUP_TIMEOUT_EN`.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — synchronous, active-high reset.
- `setup_on` in 1 — request to enter menu; sampled only in IDLE.
- `digitos_value` in senhaPac_t (20×4) — packed digits; `digits[0]` is the most recent; F = empty.
- `digitos_valid` in 1 — one-cycle strobe: entry confirmed.
- `display_en` out 1 — display owned by this block.
- `bcd_pac` out bcdPac_t (BCD0..BCD5, 4 b each) — display digits; B = blank.
- `bip_status` out 1 — committed bip enable.
- `bip_time` out 7 — committed bip time.
- `tranca_time` out 7 — committed auto-lock time.
- `senha_master` out 80 — committed master password, F-padded.
- `senha_users` out NUM_USERS×80 — committed user passwords; slot k occupies [80k+79:80k].
- `data_setup_ok` out 1 — one-cycle commit pulse.

## Operation
- **States:** IDLE, BIP_EN, BIP_TIME, LOCK_TIME, PW_MASTER, PW_USER, SAVE. PW_USER uses a slot counter `idx` in 0..NUM_USERS-1.
- **IDLE:** with `setup_on`=1, load the shadow from the committed configuration, clear `err`, go to BIP_EN. `digitos_valid` is ignored.
- **Special codes**, evaluated on `digitos_valid` in any edit state:
  - all-F: skip the field unchanged, go to the next field.
  - all-B: go to SAVE.
  - all-E: clear the pending preview to the shadow value and stay.
- **BIP_EN:** on a valid entry, `digits[0]` ∈ {0,1} writes the shadow and advances. Any other value sets `err` and stays.
- **BIP_TIME / LOCK_TIME:**
  - Value = `digits[1]`×10 + `digits[0]`; if `digits[1]`=F, value = `digits[0]`.
  - Clamp into [T_MIN,T_MAX], write the shadow, advance.
  - A non-BCD digit (A–E outside a special code) sets `err` and stays.
- **Password fields:**
  - Accept if `digits[PW_MIN-1]`≠F. Store `digits[PW_MAX-1:0]`; the upper nibbles are forced to F.
  - Fewer than PW_MIN digits: set `err`, stay.
  - In PW_USER, a candidate equal to the shadow master sets `err` and stays. The same check applies in PW_MASTER against every shadow user slot that is not all-F.
- **Field order:** PW_MASTER → PW_USER `idx`=0 → … → `idx`=NUM_USERS-1 → SAVE.
- **SAVE:** the committed configuration loads from the shadow on the transition into SAVE. SAVE lasts one cycle, then goes to IDLE.
- **`err`:** cleared by any accepted entry and on state change.
- **Display:**
  - BCD5 = field number: 1, 2, 3, 4, then 5+`idx`. BCD4 = E when `err`, else B.
  - BIP_EN: BCD0 = pending bit.
  - Time states: BCD1:BCD0 = pending value (tens/units, unclamped preview). The preview updates every cycle from `digitos_value` while `digitos_valid`=0.
  - Password states: BCD3..BCD0 blank (not echoed).
  - IDLE: `display_en`=0, all B.
  - SAVE: `display_en`=1, all B.

## Timing
- **Reset values:**
  - Outputs: `display_en`=0, `bcd_pac` all B, `data_setup_ok`=0.
  - Committed and shadow configuration: `bip_status`=1, both times = T_DEFAULT, master = 16×F followed by 1,2,3,4 (units last), users all-F.
  - State: IDLE, `idx`=0.
- Display and config outputs are Moore (decoded from registers only); no input-to-output combinational path.
- A `digitos_valid` in cycle n takes effect (state, shadow) at edge n+1. The new display is visible in cycle n+1.
- `data_setup_ok`=1 for exactly the one SAVE cycle. The new configuration is already on the outputs in that cycle and is held thereafter.
- Edits never alter committed outputs before SAVE.
- Back-to-back valid strobes on consecutive cycles are each processed.
- `rst` mid-menu: next cycle is IDLE with defaults; any partial edit is lost.

## Configuration
- **`SETUP_TIMEOUT_EN` defined:**
  - A counter resets on every `digitos_valid` and on every state change.
  - When it reaches TIMEOUT_CYCLES-1 in an edit state, go to IDLE, discard the shadow, no `data_setup_ok` pulse.
- **`SETUP_TIMEOUT_EN` undefined:** no counter; the menu waits indefinitely.

## Test plan
- Reset, then `setup_on`; valid entries "1", "7", "99", then all-B → SAVE pulse; `bip_time`=7, `tranca_time`=60 (clamped).
- Time entry "3" with `digits[1]`=F → `bip_time`=5 (clamped). Bip entry "2" → BCD4=E, state unchanged.
- Master entry "987" → err. Then "98765" → master = F…F98765. User0 entry "98765" → err, stays at BCD5=5.
- All-F through every field with NUM_USERS=2 → SAVE after 6 strobes; outputs unchanged; `data_setup_ok` pulses once.
- Edit `bip_time`, then assert `rst` before SAVE → `bip_time`=5, IDLE, `display_en`=0.
- With `SETUP_TIMEOUT_EN`, TIMEOUT_CYCLES=100: enter "1", "20", then idle 100 cycles → IDLE, `bip_time` unchanged, no ok pulse.
